dac_par_multich_driver: RTL
===========================

// Module: dac_par_multich_driver
// PURPOSE
//   Parametrised driver for latched parallel-input multi-channel DACs (TLC7528 class).
//   Accepts one frame of NCH samples on a valid/ready port and writes each enabled channel in turn.
//   For each channel it drives select, data, CS_n and WR_n with cycle-programmable setup, strobe and hold.
//   Sits between the sample-generation datapath and the DAC pins; all pin outputs are registered.
// PARAMETERS
//   DW       8   data width per channel (DAC resolution)
//   NCH      2   number of DAC channels per frame (>=1)
//   SEL_W    1   dac_sel width; must be >= max(1,$clog2(NCH))
//   T_SETUP  1   cycles sel/data/CS_n valid before WR_n falls (1..255)
//   T_WR     10  cycles WR_n held low (1..255)
//   T_HOLD   2   cycles sel/data held after WR_n rises (1..255)
// PORTS
//   clk         in   1         system clock, all logic on rising edge
//   rst         in   1         asynchronous reset, active high
//   s_valid     in   1         frame valid
//   s_ready     out  1         frame accept; transfer when s_valid & s_ready at rising clk
//   s_data      in   NCH*DW    frame samples; channel i = s_data[i*DW +: DW], unsigned
//   s_ch_en     in   NCH       per-channel write enable, sampled with the frame
//   busy        out  1         frame in progress (state != IDLE)
//   frame_done  out  1         1-cycle pulse when the last channel of a frame completes
//   dac_cs_n    out  1         DAC chip select, active low
//   dac_wr_n    out  1         DAC write strobe, active low
//   dac_sel     out  SEL_W     DAC channel address (channel index, 0 = DACA)
//   dac_data    out  DW        DAC data bus
// BEHAVIOUR
//   Reset (async, immediate):
//   - dac_cs_n=1, dac_wr_n=1, dac_sel=0, dac_data=0, busy=0, frame_done=0.
//   - State returns to IDLE; any frame in progress is discarded, with no partial strobe resumed.
//   FSM states: IDLE, SETUP, STROBE, HOLD. A down-counter (8 bit) times each phase.
//   s_ready is combinational. It is 1 in IDLE, and also in the final cycle of HOLD for the last enabled channel.
//   Accept registers s_data and s_ch_en into frame/mask registers. Port inputs are ignored while busy.
//   Channel order is ascending index; disabled channels are skipped with zero cycles spent.
//   Per enabled channel, with the phase starting on edge k:
//   - Edge k: dac_cs_n=0, dac_sel=i, dac_data=word i, state SETUP.
//   - Edge k+T_SETUP: dac_wr_n=0, state STROBE.
//   - Edge k+T_SETUP+T_WR: dac_wr_n=1, state HOLD.
//   - Edge k+P, where P = T_SETUP+T_WR+T_HOLD: next channel enters SETUP (dac_cs_n stays 0).
//   - If i was the last enabled channel: frame_done=1 for one cycle.
//   - Then, if a new frame was accepted that cycle, go to SETUP of its first enabled channel; CS_n stays low, no gap.
//   - Otherwise dac_cs_n=1, dac_sel and dac_data hold their last value, state IDLE.
//   dac_sel and dac_data never change while dac_wr_n=0 or during HOLD. dac_wr_n is never low while dac_cs_n=1.
//   Latency: accept edge to first WR_n fall = T_SETUP cycles.
//   - Frame with m enabled channels keeps CS_n low for exactly m*P cycles.
//   Frame with s_ch_en==0: accepted; frame_done pulses on the next edge; CS_n/WR_n stay high; returns to IDLE.
//   Illegal parameters (any T_*=0, NCH=0, SEL_W too small) trigger $error at elaboration/sim start.
// TESTING
//   1) Defaults. Frame {ch1=8'hA5, ch0=8'h3C}, en=2'b11.
//      -> ch0: WR_n low 10 cyc, data 3C, sel 0. Then ch1: data A5, sel 1. CS_n low 26 cyc; one frame_done.
//   2) NCH=4, en=4'b1010, data ch1=8'h11, ch3=8'h33.
//      -> Only sel 1 then sel 3 strobed. CS_n low 2*P cyc; ch0/ch2 never driven.
//   3) s_valid held high with frames F0,F1 back-to-back.
//      -> F1 accepted in F0's last HOLD cycle; CS_n stays 0 across the boundary; two frame_done pulses P*NCH apart.
//   4) en=0 frame.
//      -> Accepted; frame_done next cycle; CS_n/WR_n never low; s_ready back to 1.
//   5) rst asserted mid-STROBE of ch0.
//      -> Same cycle: WR_n=1, CS_n=1, data 0, busy 0. After release, a new frame runs cleanly from ch0.
//   6) s_data changed while busy.
//      -> dac_data still shows the captured values; checker asserts no sel/data change during WR_n low or HOLD.

Source files
------------

// File: rtl/dac_par_multich_driver.sv
// Driver for latched parallel-input multi-channel DACs (TLC7528 class).
// Accepts a frame of NCH samples plus a channel-enable mask, then writes each
// enabled channel in ascending order with programmable setup/strobe/hold.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | no frame; CS_n high, sel/data keep their last value, s_ready=1
// SETUP  | CS_n low, sel/data valid for the current channel, WR_n high
// STROBE | WR_n low, DAC latch transparent
// HOLD   | WR_n high again, sel/data still held; last cycle may chain a frame
module dac_par_multich_driver #(
  parameter int DW      = 8,
  parameter int NCH     = 2,
  parameter int SEL_W   = 1,
  parameter int T_SETUP = 1,
  parameter int T_WR    = 10,
  parameter int T_HOLD  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [NCH*DW-1:0] s_data,
  input  logic [NCH-1:0]    s_ch_en,
  output logic              busy,
  output logic              frame_done,
  output logic              dac_cs_n,
  output logic              dac_wr_n,
  output logic [SEL_W-1:0]  dac_sel,
  output logic [DW-1:0]     dac_data
);

  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

  if (NCH < 1 || SEL_W < IW) begin : g_bad_width
    $error("dac_par_multich_driver: NCH must be >= 1 and SEL_W >= max(1,clog2(NCH))");
  end
  if (T_SETUP < 1 || T_SETUP > 255 || T_WR < 1 || T_WR > 255 ||
      T_HOLD < 1 || T_HOLD > 255) begin : g_bad_timing
    $error("dac_par_multich_driver: T_SETUP/T_WR/T_HOLD must be in 1..255");
  end

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [NCH*DW-1:0]   frame_q, frame_d;
  logic [NCH-1:0]      rem_q, rem_d;
  logic                cs_d, wr_d, done_d;
  logic [SEL_W-1:0]    sel_d;
  logic [DW-1:0]       data_d;

  logic                tc, accept, launch, launch_port;
  logic [NCH-1:0]      pick_mask;
  logic [NCH*DW-1:0]   pick_data;
  logic [IW-1:0]       idx;

  // Lowest set bit of a channel mask; channels are served in ascending order.
  function automatic logic [IW-1:0] lowest(input logic [NCH-1:0] m);
    lowest = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (m[i]) lowest = IW'(i);
    end
  endfunction

  // A new frame may also be taken in the very last HOLD cycle of a frame, so
  // back-to-back frames run with CS_n held low across the boundary.
  assign tc      = (cnt_q == 8'd0);
  assign s_ready = (state_q == IDLE) || (state_q == HOLD && tc && rem_q == '0);
  assign accept  = s_valid && s_ready;
  assign busy    = (state_q != IDLE);

  // Next-state and next-pin values; every pin comes straight from a flop.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    frame_d     = frame_q;
    rem_d       = rem_q;
    cs_d        = dac_cs_n;
    wr_d        = dac_wr_n;
    sel_d       = dac_sel;
    data_d      = dac_data;
    done_d      = 1'b0;
    launch      = 1'b0;
    launch_port = 1'b0;
    pick_mask   = '0;
    pick_data   = '0;
    idx         = '0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          launch      = 1'b1;
          launch_port = 1'b1;
        end
      end
      SETUP: begin
        if (tc) begin
          wr_d    = 1'b0;
          state_d = STROBE;
          cnt_d   = 8'(T_WR - 1);
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      STROBE: begin
        if (tc) begin
          wr_d    = 1'b1;
          state_d = HOLD;
          cnt_d   = 8'(T_HOLD - 1);
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      HOLD: begin
        if (!tc) begin
          cnt_d = cnt_q - 8'd1;
        end else if (rem_q != '0) begin
          launch = 1'b1;
        end else begin
          done_d = 1'b1;
          if (accept) begin
            launch      = 1'b1;
            launch_port = 1'b1;
          end else begin
            state_d = IDLE;
            cs_d    = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Start the first/next enabled channel, or, for an all-disabled frame,
    // spend a single HOLD cycle so frame_done fires on the following edge.
    if (launch) begin
      pick_mask = launch_port ? s_ch_en : rem_q;
      pick_data = launch_port ? s_data : frame_q;
      if (launch_port) frame_d = s_data;
      if (pick_mask != '0) begin
        idx     = lowest(pick_mask);
        state_d = SETUP;
        cnt_d   = 8'(T_SETUP - 1);
        cs_d    = 1'b0;
        sel_d   = SEL_W'(idx);
        data_d  = pick_data[int'(idx)*DW +: DW];
        rem_d   = pick_mask & ~(NCH'(1) << idx);
      end else begin
        state_d = HOLD;
        cnt_d   = 8'd0;
        rem_d   = '0;
        cs_d    = 1'b1;
      end
    end
  end

  // State, phase timer, captured frame and registered DAC pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      frame_q    <= '0;
      rem_q      <= '0;
      dac_cs_n   <= 1'b1;
      dac_wr_n   <= 1'b1;
      dac_sel    <= '0;
      dac_data   <= '0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      frame_q    <= frame_d;
      rem_q      <= rem_d;
      dac_cs_n   <= cs_d;
      dac_wr_n   <= wr_d;
      dac_sel    <= sel_d;
      dac_data   <= data_d;
      frame_done <= done_d;
    end
  end

endmodule
